// File: rtl/hazard_ctrl_pkg.sv
// Shared definitions for the pipeline hazard/forwarding controller:
// RV32 opcodes, next-PC select encodings and scoreboard/decode records.
package hazard_ctrl_pkg;

  localparam logic [6:0] OPC_LUI       = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC     = 7'b0010111;
  localparam logic [6:0] OPC_JAL       = 7'b1101111;
  localparam logic [6:0] OPC_JALR      = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH    = 7'b1100011;
  localparam logic [6:0] OPC_STORE     = 7'b0100011;
  localparam logic [6:0] OPC_LOAD      = 7'b0000011;
  localparam logic [6:0] OPC_ARI_RTYPE = 7'b0110011;
  localparam logic [6:0] OPC_ARI_ITYPE = 7'b0010011;

  localparam logic [1:0] PC_JAL   = 2'd0;
  localparam logic [1:0] PC_REDIR = 2'd1;
  localparam logic [1:0] PC_PLUS4 = 2'd2;
  localparam logic [1:0] PC_HOLD  = 2'd3;

  typedef struct packed {
    logic       valid;
    logic [4:0] rd;
    logic       is_load;
  } sb_entry_t;

  localparam int SB_ENTRY_W = $bits(sb_entry_t);

  typedef struct packed {
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [4:0] rd;
    logic       uses_rs1;
    logic       uses_rs2;
    logic       writes_rd;
    logic       is_load;
    logic       is_jal;
  } dec_t;

endpackage

// File: rtl/hazard_decode.sv
// Purely combinational register-field and instruction-class decode of the
// decode-stage instruction.
module hazard_decode
  import hazard_ctrl_pkg::*;
(
  input  logic [31:0] inst,
  output dec_t        dec
);

  logic [6:0] opc;
  logic       unused_funct;

  assign opc          = inst[6:0];
  assign unused_funct = ^{inst[31:25], inst[14:12]};

  always_comb begin
    dec     = '0;
    dec.rs1 = inst[19:15];
    dec.rs2 = inst[24:20];
    dec.rd  = inst[11:7];
    unique case (opc)
      OPC_ARI_RTYPE: begin dec.uses_rs1 = 1'b1; dec.uses_rs2 = 1'b1; dec.writes_rd = 1'b1; end
      OPC_ARI_ITYPE: begin dec.uses_rs1 = 1'b1; dec.writes_rd = 1'b1; end
      OPC_LOAD:      begin dec.uses_rs1 = 1'b1; dec.writes_rd = 1'b1; dec.is_load = 1'b1; end
      OPC_STORE:     begin dec.uses_rs1 = 1'b1; dec.uses_rs2 = 1'b1; end
      OPC_BRANCH:    begin dec.uses_rs1 = 1'b1; dec.uses_rs2 = 1'b1; end
      OPC_JALR:      begin dec.uses_rs1 = 1'b1; dec.writes_rd = 1'b1; end
      OPC_LUI:       dec.writes_rd = 1'b1;
      OPC_AUIPC:     dec.writes_rd = 1'b1;
      OPC_JAL:       begin dec.writes_rd = 1'b1; dec.is_jal = 1'b1; end
      default:       ;
    endcase
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard and forwarding controller: tracks in-flight destinations over DEPTH
// post-decode stages and derives forwarding selects, stalls, flushes and next-PC.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter  int DEPTH       = 2,
  parameter  int LOAD_LAT    = 1,
  parameter  int FLUSH_DEPTH = 1,
  parameter  int CNT_W       = 32,
  localparam int SELW        = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [31:0]      inst_d,
  input  logic             valid_d,
  input  logic             redirect_x,
  output logic             stall,
  output logic             flush_d,
  output logic [SELW-1:0]  fwd_sel_a,
  output logic [SELW-1:0]  fwd_sel_b,
  output logic [1:0]       pc_sel,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] flush_count
);

  localparam int FCW = (FLUSH_DEPTH > 1) ? $clog2(FLUSH_DEPTH) : 1;

  dec_t           dec;
  sb_entry_t      sb [1:DEPTH];
  sb_entry_t      new_entry;
  logic [FCW-1:0] flush_cnt;

  logic            hit_a, rdy_a, hit_b, rdy_b;
  logic [SELW-1:0] k_a, k_b;
  logic            flush_raw, stall_raw;

  hazard_decode u_decode (
    .inst (inst_d),
    .dec  (dec)
  );

  // Scanning oldest-to-youngest lets the youngest match overwrite older ones.
  always_comb begin
    hit_a = 1'b0;
    rdy_a = 1'b0;
    k_a   = '0;
    hit_b = 1'b0;
    rdy_b = 1'b0;
    k_b   = '0;
    for (int k = DEPTH; k >= 1; k--) begin
      if (dec.uses_rs1 && sb[k].valid && (sb[k].rd == dec.rs1)) begin
        hit_a = 1'b1;
        k_a   = SELW'(k);
        rdy_a = !sb[k].is_load || (k > LOAD_LAT);
      end
      if (dec.uses_rs2 && sb[k].valid && (sb[k].rd == dec.rs2)) begin
        hit_b = 1'b1;
        k_b   = SELW'(k);
        rdy_b = !sb[k].is_load || (k > LOAD_LAT);
      end
    end
  end

  assign flush_raw = redirect_x || (flush_cnt != '0);
  assign stall_raw = valid_d && !flush_raw && ((hit_a && !rdy_a) || (hit_b && !rdy_b));

  assign new_entry.valid   = valid_d && !stall_raw && !flush_raw &&
                             dec.writes_rd && (dec.rd != 5'd0);
  assign new_entry.rd      = dec.rd;
  assign new_entry.is_load = dec.is_load;

  // Outputs are forced to their idle values for as long as reset is held.
  assign stall     = rst_n && stall_raw;
  assign flush_d   = rst_n && flush_raw;
  assign fwd_sel_a = (rst_n && hit_a && rdy_a) ? k_a : '0;
  assign fwd_sel_b = (rst_n && hit_b && rdy_b) ? k_b : '0;

  always_comb begin
    if (!rst_n)                                  pc_sel = PC_PLUS4;
    else if (redirect_x)                         pc_sel = PC_REDIR;
    else if (stall_raw)                          pc_sel = PC_HOLD;
    else if (valid_d && !flush_raw && dec.is_jal) pc_sel = PC_JAL;
    else                                         pc_sel = PC_PLUS4;
  end

  // Stage boundary: scoreboard shift, flush countdown and performance counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 1; k <= DEPTH; k++) sb[k] <= '0;
      flush_cnt   <= '0;
      stall_count <= '0;
      flush_count <= '0;
    end else begin
      sb[1] <= new_entry.valid ? new_entry : sb_entry_t'(SB_ENTRY_W'(0));
      for (int k = 2; k <= DEPTH; k++) sb[k] <= sb[k-1];
      if (redirect_x)             flush_cnt <= FCW'(FLUSH_DEPTH - 1);
      else if (flush_cnt != '0)   flush_cnt <= flush_cnt - 1'b1;
      stall_count <= stall_count + CNT_W'(stall_raw);
      flush_count <= flush_count + CNT_W'(flush_raw);
    end
  end

endmodule
